uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte queue and launch sequencer directly upstream of the UART transmitter. Accepts bytes from a producer (trace/command formatter) at up to one per clock. Buffers them in a power-of-two FIFO. Drains them one at a time into the UART's transmit/tx_byte/tx_free handshake, so the producer never has to track UART timing.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 entries of 8 bits.

Ports:
clk  in  1  master clock, shared with the UART.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  producer write strobe; accepted only when full=0.
wr_data  in  8  byte to enqueue.
flush  in  1  synchronous queue clear.
full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
empty  out  1  FIFO holds 0 bytes.
level  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
overflow  out  1  sticky flag for a rejected write; tied 0 without UART_TX_FIFO_OVF_EN.
ovf_clr  in  1  clears overflow; ignored without UART_TX_FIFO_OVF_EN.
tx_free  in  1  from UART: transmitter idle.
transmit  out  1  to UART: one-cycle launch strobe.
tx_byte  out  8  to UART: byte being launched; held stable until the next launch.

Behaviour:
- Reset (async, rst=1):
  - Pointers and level clear to 0; empty=1, full=0.
  - transmit=0, tx_byte=8'h00, overflow=0, FSM to S_IDLE.
  - Reset mid-burst discards queued bytes. A byte already handed to the UART is not recalled.
- Write path:
  - wr_en && !full at an edge stores wr_data at wr_ptr, increments wr_ptr (wraps mod depth) and increments level.
  - wr_en && full drops the byte; FIFO state is unchanged.
  - Full is judged on the pre-edge level: a pop on the same edge does not make room.
- Pop:
  - Occurs only on the S_IDLE->S_LAUNCH transition; increments rd_ptr (wraps mod depth) and decrements level.
  - Simultaneous push and pop leaves level unchanged.
- Flags: full/empty/level are registered and derived from level, not from pointer comparison. Pointers are DEPTH_LOG2 bits.
- FSM:
  - S_IDLE: if !empty && tx_free && !flush, then tx_byte<=mem[rd_ptr], transmit<=1, pop, go S_LAUNCH. Otherwise stay.
  - S_LAUNCH: transmit<=0, go S_WAIT. transmit is therefore high for exactly one cycle.
  - S_WAIT: if tx_free==0 (UART has left idle), go S_IDLE. Otherwise stay. This guards against tx_free lagging the strobe by one cycle.
- Latency: a byte written at edge E0 into an empty FIFO with tx_free=1 has transmit high from E1 to E2. The UART samples it at E2.
- Back-to-back: the next launch needs tx_free to return high after the UART's stop-bit delay. There is no launch while tx_free=1 and the FSM is in S_LAUNCH or S_WAIT.
- flush=1 at an edge:
  - Sets rd_ptr=wr_ptr=0, level=0, and blocks a launch on that edge.
  - Any wr_en on the same edge is discarded.
  - The FSM is not reset, so an in-flight S_LAUNCH/S_WAIT completes normally.
- Arithmetic: level is DEPTH_LOG2+1 bits, so it is never ambiguous at full. Pointer increments are modulo 2**DEPTH_LOG2.

Optional Feature:
UART_TX_FIFO_OVF_EN
- Defined: overflow sets on the edge where wr_en && full (flush not asserted) and stays set until ovf_clr. Set wins over a simultaneous ovf_clr.
- Not defined: overflow is constant 0, ovf_clr is unused, and no register is synthesised.

Decomposition:
- Package uart_pkg holds the FSM state typedef (S_IDLE, S_LAUNCH, S_WAIT) and the DEFAULT_TXQ_DEPTH_LOG2=4 constant.
- Sub-module sync_fifo_ram holds the memory array plus registered read port. Pointer, level and flag logic stay in uart_tx_fifo.

Test Plan:
- Single byte: write 8'hA5 with tx_free=1 -> transmit pulses exactly one cycle, 1 cycle after the write edge, with tx_byte=8'hA5. Level goes 0->1->0, empty returns to 1.
- Fill and overflow: tx_free=0, write 17 bytes 8'h00..8'h10 -> full=1 after the 16th, level=16, 8'h10 dropped. With the macro, overflow=1 until ovf_clr. Then raise tx_free, pulse it per launch -> 8'h00..8'h0F emitted in order.
- Wrap: a UART model paces tx_free; write 40 incrementing bytes in bursts of 10 -> all 40 emitted in order, across 2+ pointer wraps.
- Full plus simultaneous pop: full FIFO, wr_en of 8'hEE on the same edge as a launch pop -> 8'hEE dropped, level 16->15.
- Flush: 5 bytes queued, a launch in flight, then flush -> the in-flight byte's strobe completes, no further transmit, level=0, empty=1.
- Async reset mid-burst: rst asserted between edges with 8 bytes queued -> empty=1, level=0, transmit=0 immediately. No transmit pulse after release until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit queue.
//   DEFAULT_TXQ_DEPTH_LOG2 : default log2 of the transmit FIFO depth (16 bytes)
//   tx_state_t             : launch sequencer states
//     S_IDLE   - waiting for a queued byte and an idle transmitter
//     S_LAUNCH - launch strobe is high for this one cycle
//     S_WAIT   - waiting for the UART to drop tx_free (it has accepted the byte)
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_TXQ_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// ----------------------------------------------------------------------------
// sync_fifo_ram
// Storage for the transmit FIFO: simple dual-port array with one synchronous
// write port and one registered read port.
//   clk, rst : clock, asynchronous active-high reset (read register only)
//   we       : write strobe, stores wdata at waddr
//   waddr    : write address
//   wdata    : write data
//   re       : read strobe, captures mem[raddr] into rdata
//   raddr    : read address
//   rdata    : registered read data, holds its value until the next read
// ----------------------------------------------------------------------------
module sync_fifo_ram
    import uart_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_TXQ_DEPTH_LOG2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // elsewhere, so stale contents are never observed and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the byte presented to the UART, so it only
    // changes on a read and otherwise holds the last launched byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Byte queue and launch sequencer in front of the UART transmitter. A producer
// pushes bytes at up to one per clock; the sequencer hands them one at a time
// to the UART through the transmit / tx_byte / tx_free handshake.
//
// Optional feature macro: UART_TX_FIFO_OVF_EN
//   defined     - overflow is a sticky flag set by a write rejected while full,
//                 cleared by ovf_clr (a set on the same edge wins)
//   not defined - overflow is tied to 0 and ovf_clr is ignored
//
// Ports:
//   clk, rst  : master clock, asynchronous active-high reset
//   wr_en     : producer write strobe, accepted only when full=0
//   wr_data   : byte to enqueue
//   flush     : synchronous queue clear (also blocks a launch and a write)
//   full      : FIFO holds 2**DEPTH_LOG2 bytes (registered)
//   empty     : FIFO holds no bytes (registered)
//   level     : occupancy 0..2**DEPTH_LOG2 (registered)
//   overflow  : sticky rejected-write flag
//   ovf_clr   : clears overflow
//   tx_free   : UART transmitter idle
//   transmit  : one-cycle launch strobe to the UART
//   tx_byte   : byte being launched, stable until the next launch
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_TXQ_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    input  logic                  tx_free,
    output logic                  transmit,
    output logic [7:0]            tx_byte
);

    localparam int                DEPTH      = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  push;
    logic                  launch;
    tx_state_t             state;
    tx_state_t             state_next;

    // Full is judged on the registered (pre-edge) level, so a pop on the same
    // edge never makes room for a write.
    assign push = wr_en && !full && !flush;

    // ------------------------------------------------------------------
    // Launch sequencer
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!empty && tx_free && !flush) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: state_next = S_WAIT;
            // tx_free may lag the strobe by a cycle; only a low tx_free proves
            // the UART has taken the byte.
            S_WAIT: begin
                if (!tx_free) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        launch   = (state == S_IDLE) && (state_next == S_LAUNCH);
        transmit = (state == S_LAUNCH);
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else begin
            case ({push, launch})
                2'b10:   level_next = level + 1'b1;
                2'b01:   level_next = level - 1'b1;
                default: level_next = level;
            endcase
        end
    end

    // Flags come from the occupancy count, never from pointer comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            level <= level_next;
            full  <= (level_next == LEVEL_FULL);
            empty <= (level_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Storage; the read register is tx_byte itself
    // ------------------------------------------------------------------
    sync_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (8)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (launch),
        .raddr (rd_ptr),
        .rdata (tx_byte)
    );

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------
`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full && !flush) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. A queue-based reference model predicts
// every output after every clock edge; table vectors and directed sequences add
// explicit expectations for the corner cases, and a paced UART model drives
// tx_free during draining and randomized traffic.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr;
    logic       tx_free;
    logic       transmit;
    logic [7:0] tx_byte;

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_free  (tx_free),
        .transmit (transmit),
        .tx_byte  (tx_byte)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue contents, launch phase, last byte handed over.
    // m_age: 0 = free to launch, 1 = strobe high now, 2 = waiting for tx_free low
    logic [7:0] m_q[$];
    int         m_age;
    logic [7:0] m_last;
    bit         m_ovf;

    // Bytes actually seen on the UART side
    logic [7:0] dut_out[$];

    // Paced UART model
    int   u_lag;
    int   u_busy;
    logic u_tf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_ovf();
`ifdef UART_TX_FIFO_OVF_EN
        return m_ovf;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_age  = 0;
        m_last = 8'h00;
        m_ovf  = 1'b0;
        u_lag  = 0;
        u_busy = 0;
        u_tf   = 1'b1;
    endfunction

    // Applies the behavioural rules for one clock edge with the given inputs.
    function automatic void model_step(input logic we, input logic [7:0] d,
                                       input logic fl, input logic tf, input logic clr);
        bit pre_full;
        bit do_launch;
        pre_full  = (m_q.size() == DEPTH);
        do_launch = (m_age == 0) && (m_q.size() != 0) && tf && !fl;
        if (we && pre_full && !fl) m_ovf = 1'b1;
        else if (clr)              m_ovf = 1'b0;
        if (fl) begin
            m_q.delete();
        end else begin
            if (do_launch)         m_last = m_q.pop_front();
            if (we && !pre_full)   m_q.push_back(d);
        end
        case (m_age)
            0:       m_age = do_launch ? 1 : 0;
            1:       m_age = 2;
            default: m_age = tf ? 2 : 0;
        endcase
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".transmit"}, 32'(transmit), 32'(m_age == 1));
        check({tag, ".tx_byte"},  32'(tx_byte),  32'(m_last));
        check({tag, ".level"},    32'(level),    32'(m_q.size()));
        check({tag, ".empty"},    32'(empty),    32'(m_q.size() == 0));
        check({tag, ".full"},     32'(full),     32'(m_q.size() == DEPTH));
        check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf()));
    endtask

    // One clock: drive inputs, advance model, sample 1 ns after the edge.
    task automatic cycle(input logic we, input logic [7:0] d, input logic fl,
                         input logic tf, input logic clr);
        wr_en   = we;
        wr_data = d;
        flush   = fl;
        tx_free = tf;
        ovf_clr = clr;
        model_step(we, d, fl, tf, clr);
        @(posedge clk);
        #1;
        compare_all("cyc");
        if (transmit === 1'b1) dut_out.push_back(tx_byte);
    endtask

    // UART reacts to a launch: optional one-cycle lag, then busy for a while.
    function automatic void uart_update();
        if (m_age == 1) begin
            u_lag  = int'($urandom_range(0, 1));
            u_busy = int'($urandom_range(2, 6));
        end
        if (u_lag > 0) begin
            u_lag--;
            u_tf = 1'b1;
        end else if (u_busy > 0) begin
            u_busy--;
            u_tf = 1'b0;
        end else begin
            u_tf = 1'b1;
        end
    endfunction

    task automatic pcycle(input logic we, input logic [7:0] d, input logic fl, input logic clr);
        cycle(we, d, fl, u_tf, clr);
        uart_update();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((m_q.size() != 0 || m_age != 0) && k < 1000) begin
            pcycle(1'b0, 8'h00, 1'b0, 1'b0);
            k++;
        end
        check({name, ".drain_done"}, 32'(k < 1000), 32'd1);
    endtask

    task automatic check_seq(input string name, input logic [7:0] exp[$]);
        check({name, ".count"}, 32'(dut_out.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_out.size(); i++) begin
            check($sformatf("%s.byte%0d", name, i), 32'(dut_out[i]), 32'(exp[i]));
        end
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        flush   = 1'b0;
        ovf_clr = 1'b0;
        tx_free = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset.level",    32'(level),    32'd0);
        check("reset.empty",    32'(empty),    32'd1);
        check("reset.full",     32'(full),     32'd0);
        check("reset.transmit", 32'(transmit), 32'd0);
        check("reset.tx_byte",  32'(tx_byte),  32'h00);
        check("reset.overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dut_out.delete();
    endtask

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       flush;
        logic       tx_free;
        logic       exp_transmit;
        logic [7:0] exp_tx_byte;
        logic [4:0] exp_level;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_q[$];
        int         tx_cnt;

        // Single byte latency, strobe width, flush interaction with writes
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0};
        vecs[5] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd0};
        vecs[6] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1};
        vecs[7] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd0};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0};

        reset_dut();

        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].wr_en, vecs[i].wr_data, vecs[i].flush, vecs[i].tx_free, 1'b0);
            check($sformatf("vec%0d.transmit", i), 32'(transmit), 32'(vecs[i].exp_transmit));
            check($sformatf("vec%0d.tx_byte", i),  32'(tx_byte),  32'(vecs[i].exp_tx_byte));
            check($sformatf("vec%0d.level", i),    32'(level),    32'(vecs[i].exp_level));
        end

        // Fill and overflow
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 15) begin
                check("fill.full16",  32'(full),  32'd1);
                check("fill.level16", 32'(level), 32'd16);
            end
        end
        check("fill.level_after_drop", 32'(level), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
        check("fill.overflow_set", 32'(overflow), 32'd1);
`else
        check("fill.overflow_tied", 32'(overflow), 32'd0);
`endif
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("fill.overflow_clr", 32'(overflow), 32'd0);
        dut_out.delete();
        drain("fill");
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        check_seq("fill.order", exp_q);

        // Full FIFO, rejected write on the same edge as a launch pop
        reset_dut();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        dut_out.delete();
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check("fullpop.level",    32'(level),    32'd15);
        check("fullpop.transmit", 32'(transmit), 32'd1);
        check("fullpop.tx_byte",  32'(tx_byte),  32'hC0);
        uart_update();
        drain("fullpop");
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hC0 + 8'(i));
        check_seq("fullpop.order", exp_q);

        // Pointer wrap: 40 bytes in bursts of 10 with a paced UART
        reset_dut();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) pcycle(1'b1, 8'(b * 10 + i), 1'b0, 1'b0);
            drain($sformatf("wrap%0d", b));
        end
        exp_q.delete();
        for (int i = 0; i < 40; i++) exp_q.push_back(8'(i));
        check_seq("wrap.order", exp_q);

        // Flush with a launch in flight
        reset_dut();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("flush.launch_transmit", 32'(transmit), 32'd1);
        check("flush.launch_byte",     32'(tx_byte),  32'h50);
        check("flush.launch_level",    32'(level),    32'd4);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("flush.strobe_ends", 32'(transmit), 32'd0);
        check("flush.level",       32'(level),    32'd0);
        check("flush.empty",       32'(empty),    32'd1);
        tx_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 1'b0, logic'(i % 2), 1'b0);
            if (transmit === 1'b1) tx_cnt++;
        end
        check("flush.no_more_tx", 32'(tx_cnt), 32'd0);

        // Asynchronous reset between edges with 8 bytes queued
        reset_dut();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("arst.pre_transmit", 32'(transmit), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst.transmit", 32'(transmit), 32'd0);
        check("arst.level",    32'(level),    32'd0);
        check("arst.empty",    32'(empty),    32'd1);
        check("arst.full",     32'(full),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        tx_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            if (transmit === 1'b1) tx_cnt++;
        end
        check("arst.no_tx_after", 32'(tx_cnt), 32'd0);

        // Randomized traffic against the reference model
        reset_dut();
        for (int i = 0; i < 900; i++) begin
            int wprob;
            wprob = ((i / 150) % 2 == 0) ? 80 : 20;
            pcycle(logic'($urandom_range(0, 99) < wprob), 8'($urandom),
                   logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 9) == 0));
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
